control_loop_cmd_bridge: RTL and testbench

//  Host-side command front end for control_loop. Accepts one command/word request at a time on a

---
 rtl/control_loop_cmd_bridge_pkg.sv | 9 +
 rtl/control_loop_cmd_bridge.sv | 95 +++++++++
 tb/tb_control_loop_cmd_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_loop_cmd_bridge_pkg.sv
// control_loop_cmd_bridge_pkg: command width, command codes and bridge FSM states shared with control_loop users.
package control_loop_cmd_bridge_pkg;
   localparam int CONTROL_LOOP_CMD_WIDTH = 8;
   localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_NOP   = 8'h00;
   localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_READ  = 8'h01;
   localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_WRITE = 8'h02;
   localparam logic [CONTROL_LOOP_CMD_WIDTH-1:0] CL_CMD_RUN   = 8'h03;
   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;
endpackage

// File: rtl/control_loop_cmd_bridge.sv
// control_loop_cmd_bridge: host valid/ready front end running the start_cmd/finish_cmd handshake with a timeout.
module control_loop_cmd_bridge
   import control_loop_cmd_bridge_pkg::*;
#(
   parameter int CONSTS_WID  = 48,
   parameter int CMD_WID     = CONTROL_LOOP_CMD_WIDTH,
   parameter int TIMEOUT_WID = 16,
   parameter int TIMEOUT     = 'hFFFF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [CMD_WID-1:0]     req_cmd,
   input  logic [CONSTS_WID-1:0]  req_word,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [CONSTS_WID-1:0]  rsp_word,
   output logic                   rsp_err,
   output logic [CMD_WID-1:0]     cmd,
   output logic [CONSTS_WID-1:0]  word_into_loop,
   output logic                   start_cmd,
   input  logic                   finish_cmd,
   input  logic [CONSTS_WID-1:0]  word_outof_loop
);
   state_t state, state_d;
   logic [TIMEOUT_WID-1:0] timer, timer_d, timer_inc;
   logic [CMD_WID-1:0] cmd_d;
   logic [CONSTS_WID-1:0] word_d, rsp_word_d;
   logic idle, start_d, rsp_valid_d, rsp_err_d, timer_last;
   // idle is a flop cleared by reset so req_ready drops asynchronously; the finish_cmd term blocks stale finishes
   assign req_ready = idle && !finish_cmd;
   assign timer_last = timer == TIMEOUT_WID'(TIMEOUT - 1);
   assign timer_inc = &timer ? timer : timer + 1'b1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idle <= 1'b0;
         timer <= '0;
         cmd <= '0;
         word_into_loop <= '0;
         start_cmd <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_word <= '0;
         rsp_err <= 1'b0;
      end else begin
         state <= state_d;
         idle <= state_d == IDLE;
         timer <= timer_d;
         cmd <= cmd_d;
         word_into_loop <= word_d;
         start_cmd <= start_d;
         rsp_valid <= rsp_valid_d;
         rsp_word <= rsp_word_d;
         rsp_err <= rsp_err_d;
      end
   end
   always_comb begin
      state_d = state;
      timer_d = timer;
      cmd_d = cmd;
      word_d = word_into_loop;
      start_d = start_cmd;
      rsp_valid_d = rsp_valid;
      rsp_word_d = rsp_word;
      rsp_err_d = rsp_err;
      case (state)
         IDLE: if (req_valid && req_ready) begin
            cmd_d = req_cmd;
            word_d = req_word;
            start_d = 1'b1;
            timer_d = '0;
            state_d = ISSUE;
         end
         ISSUE: if (finish_cmd || timer_last) begin
            rsp_word_d = finish_cmd ? word_outof_loop : '0;
            rsp_err_d = !finish_cmd;
            start_d = 1'b0;
            timer_d = '0;
            state_d = RELEASE;
         end else timer_d = timer_inc;
         RELEASE: if (!finish_cmd || timer_last) begin
            rsp_err_d = rsp_err || finish_cmd;
            rsp_word_d = finish_cmd ? '0 : rsp_word;
            rsp_valid_d = 1'b1;
            state_d = RESP;
         end else timer_d = timer_inc;
         RESP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_control_loop_cmd_bridge.sv
// tb_control_loop_cmd_bridge: directed bench with a behavioural control_loop and a response scoreboard.
module tb_control_loop_cmd_bridge;
   import control_loop_cmd_bridge_pkg::*;
   logic clk = 0, rst = 1;
   logic req_valid = 0, rsp_ready = 1, force_fin = 0;
   logic [7:0] req_cmd = 0;
   logic [47:0] req_word = 0;
   logic req_ready, rsp_valid, rsp_err, start_cmd, finish_cmd;
   logic [47:0] rsp_word, word_into_loop, word_outof_loop;
   logic [7:0] cmd;
   logic fin_m, loop_en = 1, use_fn = 0;
   logic [47:0] out_m, loop_fixed = 48'hABCD;
   int loop_lat = 4, cnt;
   int errors = 0, checks = 0;
   logic [48:0] sb[$];
   always #5 clk = ~clk;
   control_loop_cmd_bridge #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
      .req_word(req_word), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
      .rsp_err(rsp_err), .cmd(cmd), .word_into_loop(word_into_loop), .start_cmd(start_cmd),
      .finish_cmd(finish_cmd), .word_outof_loop(word_outof_loop)
   );
   function automatic logic [47:0] fn(input logic [7:0] c, input logic [47:0] w);
      return {w[23:0], w[47:24]} ^ {40'h0, c};
   endfunction
   // loop model: finish rises loop_lat+1 cycles after start is seen, falls once start drops
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fin_m <= 0;
         cnt <= 0;
         out_m <= 0;
      end else if (!start_cmd) begin
         fin_m <= 0;
         cnt <= 0;
      end else if (loop_en && !fin_m) begin
         if (cnt == loop_lat) begin
            fin_m <= 1;
            out_m <= use_fn ? fn(cmd, word_into_loop) : loop_fixed;
         end else cnt <= cnt + 1;
      end
   end
   assign finish_cmd = fin_m | force_fin;
   assign word_outof_loop = out_m;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) chk("rsp_unexpected", 64'(sb.size()), 1);
         else begin
            logic [48:0] e;
            e = sb.pop_front();
            chk("rsp_word", rsp_word, e[47:0]);
            chk("rsp_err", rsp_err, e[48]);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] c, input logic [47:0] w, input logic [48:0] e, input bit push, input bit keep);
      int n = 0;
      req_cmd = c;
      req_word = w;
      req_valid = 1;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept", req_ready, 1);
      if (push) sb.push_back(e);
      tick();
      if (!keep) req_valid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("drain", 64'(sb.size()), 0);
   endtask
   initial begin
      int n;
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_start", start_cmd, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_word", rsp_word, 0);
      tick();
      rst = 0;
      tick();
      chk("idle_req_ready", req_ready, 1);
      // normal transaction
      send(CL_CMD_WRITE, 48'h0000_1234_5678, {1'b0, 48'hABCD}, 1, 0);
      chk("n_start", start_cmd, 1);
      chk("n_cmd", cmd, CL_CMD_WRITE);
      chk("n_word", word_into_loop, 48'h0000_1234_5678);
      chk("n_req_ready", req_ready, 0);
      n = 0;
      while (!finish_cmd && n < 50) begin
         tick();
         n++;
      end
      chk("n_finish_delay", n, 5);
      chk("n_start_held", start_cmd, 1);
      tick();
      chk("n_start_drop", start_cmd, 0);
      drain();
      // backpressure: response held while rsp_ready=0, next request waits
      rsp_ready = 0;
      send(8'h05, 48'h1111_2222_3333, {1'b0, 48'hABCD}, 1, 0);
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      req_cmd = 8'h06;
      req_word = 48'h4444;
      req_valid = 1;
      for (int i = 0; i < 20; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_word", rsp_word, 48'hABCD);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_start", start_cmd, 0);
         tick();
      end
      rsp_ready = 1;
      loop_fixed = 48'h5A5A;
      send(8'h06, 48'h4444, {1'b0, 48'h5A5A}, 1, 0);
      chk("bp_accept_cmd", cmd, 8'h06);
      drain();
      // ISSUE timeout with a loop that never finishes
      loop_en = 0;
      send(CL_CMD_RUN, 48'h77, {1'b1, 48'h0}, 1, 0);
      n = 0;
      while (start_cmd && n < 100) begin
         tick();
         n++;
      end
      chk("to_start_width", n, 16);
      drain();
      force_fin = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("late_rsp_valid", rsp_valid, 0);
         chk("late_req_ready", req_ready, 0);
      end
      force_fin = 0;
      loop_en = 1;
      tick();
      // stale finish in IDLE blocks acceptance
      force_fin = 1;
      req_cmd = CL_CMD_READ;
      req_word = 48'h99;
      req_valid = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stale_req_ready", req_ready, 0);
         chk("stale_start", start_cmd, 0);
      end
      force_fin = 0;
      loop_fixed = 48'hC0FFEE;
      send(CL_CMD_READ, 48'h99, {1'b0, 48'hC0FFEE}, 1, 0);
      chk("stale_start_after", start_cmd, 1);
      drain();
      // finish stuck high through RELEASE times out as an error
      loop_lat = 0;
      send(CL_CMD_RUN, 48'h42, {1'b1, 48'h0}, 1, 0);
      force_fin = 1;
      drain();
      force_fin = 0;
      tick();
      tick();
      // asynchronous reset in the middle of ISSUE
      loop_lat = 10;
      send(CL_CMD_WRITE, 48'hDEAD, 49'h0, 0, 0);
      tick();
      chk("rst_mid_start_pre", start_cmd, 1);
      #3;
      rst = 1;
      #1;
      chk("rst_mid_start", start_cmd, 0);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_req_ready", req_ready, 0);
      tick();
      rst = 0;
      tick();
      chk("rst_mid_ready_after", req_ready, 1);
      loop_lat = 2;
      loop_fixed = 48'hBEEF;
      send(CL_CMD_WRITE, 48'hF00D, {1'b0, 48'hBEEF}, 1, 0);
      drain();
      // back-to-back requests with req_valid held high
      use_fn = 1;
      loop_lat = 1;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] c;
         logic [47:0] w;
         c = 8'(i + 1);
         w = 48'h1000_0000_0001 * 48'(i + 3);
         send(c, w, {1'b0, fn(c, w)}, 1, i != 3);
      end
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end
endmodule
